// File: rtl/stream_arb_pkg.sv
// Shared types and default sizing for the stream round-robin arbiter.
package stream_arb_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_PAYLOAD_BITS = 32;
    localparam int DEF_BURST_LEN    = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit searching upward from last_i+1 (mod NUM_REQ).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_o
);

    // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx     = '0;
        grant_o = '0;
        any_o   = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                grant_o = idx;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ valid/ack streams into one registered output.
// Optional per-requester accepted-word counters are built when ARB_WORD_COUNT_EN is defined.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int BURST_LEN    = DEF_BURST_LEN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
    input  logic [NUM_REQ-1:0]              vld_user2arb,
    output logic [NUM_REQ-1:0]              ack_arb2user,
    output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
    output logic                            vld_arb2interface,
    input  logic                            ack_interface2arb,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic [NUM_REQ*16-1:0]           word_count
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic [IW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    full_q, full_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;

    logic [PAYLOAD_BITS-1:0] words [NUM_REQ];
    logic [IW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    grant_vld;
    logic                    up_xfer;
    logic                    down_xfer;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
        assign words[gi] = din_user2arb[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .req_i   (vld_user2arb),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    assign grant_vld = vld_user2arb[grant_q];
    assign down_xfer = full_q && ack_interface2arb;
    // Upstream may refill the output register on the same edge it drains.
    assign up_xfer   = (state_q == ST_BURST) && grant_vld && (!full_q || ack_interface2arb);

    always_comb begin
        ack_arb2user = '0;
        if (up_xfer) begin
            ack_arb2user[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        data_d  = data_q;

        if (up_xfer) begin
            full_d = 1'b1;
            data_d = words[grant_q];
        end else if (down_xfer) begin
            full_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!grant_vld) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else if (up_xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            data_q  <= data_d;
        end
    end

    assign dout_arb2interface = data_q;
    assign vld_arb2interface  = full_q;
    assign grant_id           = grant_q;
    assign busy               = (state_q == ST_BURST);

`ifdef ARB_WORD_COUNT_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wc
        logic [15:0] wc_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wc_q <= '0;
            end else if (ack_arb2user[gi]) begin
                wc_q <= wc_q + 16'd1;
            end
        end
        assign word_count[gi*16 +: 16] = wc_q;
    end
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized and directed bench for stream_rr_arbiter against a transaction-level reference model.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int PB = 32;
    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*PB-1:0]   din;
    logic [N-1:0]      vld;
    logic [N-1:0]      ack_arb2user;
    logic [PB-1:0]     dout_arb2interface;
    logic              vld_arb2interface;
    logic              ack_if;
    logic [1:0]        grant_id;
    logic              busy;
    logic [N*16-1:0]   word_count;

    stream_rr_arbiter #(
        .NUM_REQ      (N),
        .PAYLOAD_BITS (PB),
        .BURST_LEN    (BL)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .din_user2arb       (din),
        .vld_user2arb       (vld),
        .ack_arb2user       (ack_arb2user),
        .dout_arb2interface (dout_arb2interface),
        .vld_arb2interface  (vld_arb2interface),
        .ack_interface2arb  (ack_if),
        .grant_id           (grant_id),
        .busy               (busy),
        .word_count         (word_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: who owns the output, how many words into the burst, what is buffered.
    bit          m_burst;
    bit          m_full;
    int          m_grant;
    int          m_last;
    int          m_cnt;
    logic [PB-1:0] m_data;
    logic [15:0] m_wc [N];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_burst = 0;
        m_full  = 0;
        m_grant = 0;
        m_last  = N - 1;
        m_cnt   = 0;
        m_data  = '0;
        for (int i = 0; i < N; i++) m_wc[i] = '0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N*16-1:0] exp_wc();
        logic [N*16-1:0] r;
        r = '0;
`ifdef ARB_WORD_COUNT_EN
        for (int i = 0; i < N; i++) r[i*16 +: 16] = m_wc[i];
`endif
        return r;
    endfunction

    // Called just after inputs are driven on a falling edge; returns the DUT's downstream transfer.
    task automatic run_cycle(output logic [N-1:0] acked, output bit xfer, output logic [PB-1:0] xdata);
        logic [N-1:0] ea;
        bit up, down;
        #1;
        ea = '0;
        if (m_burst && vld[m_grant] && (!m_full || ack_if)) ea[m_grant] = 1'b1;
        check_val("ack", {60'd0, ack_arb2user}, {60'd0, ea});
        acked = ea;
        xfer  = vld_arb2interface && ack_if;
        xdata = dout_arb2interface;
        @(posedge clk);
        up   = (ea != 0);
        down = m_full && ack_if;
        if (down) $display("xfer  word=0x%08h grant=%0d", m_data, m_grant);
        if (up) begin
            m_data = din[m_grant*PB +: PB];
            m_full = 1;
            m_wc[m_grant]++;
        end else if (down) begin
            m_full = 0;
        end
        if (!m_burst) begin
            if (vld != 0) begin
                m_grant = pick(vld, m_last);
                m_cnt   = 0;
                m_burst = 1;
            end
        end else if (!vld[m_grant]) begin
            m_burst = 0;
            m_last  = m_grant;
        end else if (up) begin
            m_cnt++;
            if (m_cnt == BL) begin
                m_burst = 0;
                m_last  = m_grant;
            end
        end
        @(negedge clk);
        check_val("vld_out", {63'd0, vld_arb2interface}, {63'd0, m_full});
        check_val("dout", {32'd0, dout_arb2interface}, {32'd0, m_data});
        check_val("grant_id", {62'd0, grant_id}, 64'(m_grant));
        check_val("busy", {63'd0, busy}, {63'd0, m_burst});
        check_val("word_count", word_count, exp_wc());
    endtask

    initial begin
        logic [N-1:0]  acked;
        bit            xfer;
        logic [PB-1:0] xdata;
        logic [PB-1:0] held;
        int            gseq [$];
        logic [PB-1:0] dseq [$];
        bit            prev_busy;
        int            n2;
        int            t;

        reset  = 1'b1;
        vld    = '0;
        din    = '0;
        ack_if = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_ack", {60'd0, ack_arb2user}, 64'd0);
        check_val("rst_vld", {63'd0, vld_arb2interface}, 64'd0);
        check_val("rst_dout", {32'd0, dout_arb2interface}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_grant", {62'd0, grant_id}, 64'd0);
        check_val("rst_wc", word_count, 64'd0);
        reset = 1'b0;

        // All requesters valid, downstream always ready: grant order 0,1,2,3,0.
        vld = '1;
        ack_if = 1'b1;
        prev_busy = 0;
        for (int c = 0; c < 26; c++) begin
            for (int i = 0; i < N; i++) din[i*PB +: PB] = {8'(i), 24'(c)};
            run_cycle(acked, xfer, xdata);
            if (busy && !prev_busy) gseq.push_back(int'(grant_id));
            prev_busy = busy;
        end
        check_val("order_len_ok", 64'(gseq.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < gseq.size(); i++)
            check_val($sformatf("order[%0d]", i), 64'(gseq[i]), 64'(i % N));

        // Only requester 2, words 0xA0 upward, each advancing on its own ack.
        vld = '0;
        repeat (3) begin
            @(negedge clk);
            run_cycle(acked, xfer, xdata);
        end
        vld = 4'b0100;
        n2 = 0;
        for (int c = 0; c < 12; c++) begin
            din[2*PB +: PB] = 32'h0000_00A0 + 32'(n2);
            run_cycle(acked, xfer, xdata);
            if (xfer) dseq.push_back(xdata);
            if (acked[2]) n2++;
        end
        check_val("req2_len_ok", 64'(dseq.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < dseq.size(); i++)
            check_val($sformatf("req2_word[%0d]", i), {32'd0, dseq[i]}, 64'h0A0 + 64'(i));

        // Downstream stall mid-burst: output word must hold.
        vld = '1;
        for (t = 0; t < 10 && !(m_burst && m_full); t++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            run_cycle(acked, xfer, xdata);
        end
        check_val("stall_setup_timeout", 64'(t < 10), 64'd1);
        ack_if = 1'b0;
        held = dout_arb2interface;
        repeat (3) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            run_cycle(acked, xfer, xdata);
            check_val("stall_dout_stable", {32'd0, dout_arb2interface}, {32'd0, held});
            check_val("stall_no_ack", {60'd0, ack_arb2user}, 64'd0);
        end
        ack_if = 1'b1;
        repeat (3) run_cycle(acked, xfer, xdata);

        // Requester 2 drops after two words while 3 waits: 3 is granted next.
        vld = '0;
        repeat (3) run_cycle(acked, xfer, xdata);
        vld = 4'b0100;
        for (t = 0; t < 5 && !m_burst; t++) run_cycle(acked, xfer, xdata);
        check_val("drop_grant2_timeout", 64'(m_burst && m_grant == 2), 64'd1);
        vld = 4'b1100;
        n2 = 0;
        for (t = 0; t < 10 && n2 < 2; t++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            run_cycle(acked, xfer, xdata);
            if (acked[2]) n2++;
        end
        check_val("drop_two_words", 64'(n2), 64'd2);
        vld = 4'b1000;
        run_cycle(acked, xfer, xdata);
        check_val("drop_idle", {63'd0, busy}, 64'd0);
        for (t = 0; t < 5 && !busy; t++) run_cycle(acked, xfer, xdata);
        check_val("drop_next_grant", {62'd0, grant_id}, 64'd3);

        // Reset while a word is held mid-burst.
        vld = '1;
        ack_if = 1'b0;
        for (t = 0; t < 10 && !(m_burst && m_full); t++) run_cycle(acked, xfer, xdata);
        check_val("rst_setup_timeout", 64'(t < 10), 64'd1);
        reset = 1'b1;
        #1;
        check_val("midrst_vld", {63'd0, vld_arb2interface}, 64'd0);
        check_val("midrst_busy", {63'd0, busy}, 64'd0);
        check_val("midrst_ack", {60'd0, ack_arb2user}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        ack_if = 1'b1;
        for (t = 0; t < 5 && !busy; t++) run_cycle(acked, xfer, xdata);
        check_val("midrst_first_grant", {62'd0, grant_id}, 64'd0);

        // Random traffic with sticky, occasionally toggling valids.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) vld[i] = ~vld[i];
                din[i*PB +: PB] = $urandom;
            end
            ack_if = ($urandom_range(0, 3) != 0);
            run_cycle(acked, xfer, xdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
